// File: rtl/led_pattern_sched.sv
// ============================================================================
// Module   : led_pattern_sched
// Purpose  : 4-LED shift-display sequencer: step prescaler, mode button
//            debouncer and pattern mode FSM. LED_ACTIVE_LOW_EN inverts led.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sched #(
  parameter int STEP_DIV   = 2700000,
  parameter int DEB_CYCLES = 270000,
  parameter int NLED       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_mode,
  input  logic            run,
  output logic [NLED-1:0] led,
  output logic [1:0]      mode,
  output logic            step_tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    JOHNSON_L = 2'd0,
    JOHNSON_R = 2'd1,
    BOUNCE    = 2'd2,
    HOLD      = 2'd3
  } mode_e;

  mode_e           mode_q, mode_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [NLED-1:0] led_q, led_d;
  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic            dir_up_q, dir_up_d;
  logic            tick_q, tick_d;
  logic            mode_adv;
  logic            step;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= JOHNSON_L;
      cnt_q     <= '0;
      deb_cnt_q <= '0;
      led_q     <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      dir_up_q  <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      deb_cnt_q <= deb_cnt_d;
      led_q     <= led_d;
      sync1_q   <= btn_mode;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      dir_up_q  <= dir_up_d;
      tick_q    <= tick_d;
    end
  end

  // The counter only runs while the sample disagrees with the accepted level.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    mode_adv  = 1'b0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d    = sync2_q;
        mode_adv = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_adv) begin
      case (mode_q)
        JOHNSON_L: mode_d = JOHNSON_R;
        JOHNSON_R: mode_d = BOUNCE;
        BOUNCE:    mode_d = HOLD;
        default:   mode_d = JOHNSON_L;
      endcase
    end
  end

  // A mode change in the step cycle swallows that step.
  assign step = (cnt_q == CNT_LAST) && run && !mode_adv;

  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    led_d    = led_q;
    dir_up_d = dir_up_q;
    tick_d   = step;
    if (mode_adv) begin
      cnt_d = '0;
      if (mode_d != HOLD) begin
        led_d    = '0;
        dir_up_d = 1'b1;
      end
    end else if (step) begin
      case (mode_q)
        JOHNSON_L: led_d = {led_q[NLED-2:0], ~led_q[NLED-1]};
        JOHNSON_R: led_d = {~led_q[0], led_q[NLED-1:1]};
        BOUNCE: begin
          if (led_q == '0) begin
            led_d    = NLED'(1);
            dir_up_d = 1'b1;
          end else if (dir_up_q && led_q[NLED-1]) begin
            dir_up_d = 1'b0;
            led_d    = led_q >> 1;
          end else if (!dir_up_q && led_q[0]) begin
            dir_up_d = 1'b1;
            led_d    = led_q << 1;
          end else if (dir_up_q) begin
            led_d = led_q << 1;
          end else begin
            led_d = led_q >> 1;
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_q;
`else
  assign led = led_q;
`endif
  assign mode      = mode_q;
  assign step_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sched.sv
// Randomized bench for led_pattern_sched against a pattern-index reference model.
`default_nettype none

module tb_led_pattern_sched;

  localparam int STEP_DIV = 10;
  localparam int DEB      = 4;
  localparam int NLED     = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            btn_mode;
  logic            run;
  logic [NLED-1:0] led;
  logic [1:0]      mode;
  logic            step_tick;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int              m_mode;
  int              m_k;
  int              m_j;
  int              m_b;
  logic [NLED-1:0] m_led;
  bit              m_tick;
  bit              m_level;
  bit              hist [DEB+3];

  bit btnv;
  bit runv;
  int btn_left;

  always #5 clk = ~clk;

  led_pattern_sched #(
    .STEP_DIV  (STEP_DIV),
    .DEB_CYCLES(DEB),
    .NLED      (NLED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .run      (run),
    .led      (led),
    .mode     (mode),
    .step_tick(step_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [NLED-1:0] johnson_l(input int j);
    logic [NLED-1:0] ones;
    ones = '1;
    if (j <= NLED) return ones >> (NLED - j);
    return ones << (j - NLED);
  endfunction

  function automatic logic [NLED-1:0] johnson_r(input int j);
    logic [NLED-1:0] l, r;
    l = johnson_l(j);
    for (int i = 0; i < NLED; i++) r[i] = l[NLED-1-i];
    return r;
  endfunction

  function automatic logic [NLED-1:0] bounce(input int b);
    logic [NLED-1:0] one;
    int p;
    one = 1;
    p = b % (2*NLED - 2);
    if (p >= NLED) p = 2*NLED - 2 - p;
    return one << p;
  endfunction

  // One rising edge of the reference: a level is accepted once the synchronised
  // sample (raw sample two edges back) has disagreed with it for DEB+1 samples.
  task automatic model_edge(input bit b, input bit r, input bit rs);
    bit flip, adv, opp;
    if (rs) begin
      m_mode = 0; m_k = 0; m_j = 0; m_b = -1;
      m_led = '0; m_tick = 0; m_level = 0;
      for (int i = 0; i < DEB+3; i++) hist[i] = 0;
    end else begin
      for (int i = DEB+2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = b;
      flip = 1;
      for (int i = 2; i <= DEB+2; i++) if (hist[i] == m_level) flip = 0;
      adv = flip && !m_level;
      if (flip) m_level = ~m_level;
      opp = ((m_k + 1) % STEP_DIV) == 0;
      if (adv) begin
        m_mode = (m_mode + 1) % 4;
        m_k    = 0;
        m_tick = 0;
        if (m_mode != 3) begin
          m_led = '0; m_j = 0; m_b = -1;
        end
      end else begin
        m_k++;
        m_tick = opp && r;
        if (m_tick) begin
          case (m_mode)
            0: begin m_j = (m_j + 1) % (2*NLED); m_led = johnson_l(m_j); end
            1: begin m_j = (m_j + 1) % (2*NLED); m_led = johnson_r(m_j); end
            2: begin m_b++; m_led = bounce(m_b); end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic cyc(input bit b, input bit r, input bit rs);
    logic [NLED-1:0] exp_led;
    btn_mode = b;
    run      = r;
    rst      = rs;
    @(posedge clk);
    model_edge(b, r, rs);
    @(negedge clk);
`ifdef LED_ACTIVE_LOW_EN
    exp_led = ~m_led;
`else
    exp_led = m_led;
`endif
    check_eq("led", {28'd0, led}, {28'd0, exp_led});
    check_eq("mode", {30'd0, mode}, m_mode);
    check_eq("step_tick", {31'd0, step_tick}, {31'd0, m_tick});
  endtask

  // Press timed so the mode change lands on the prescaler's last count.
  task automatic aim_press();
    int n;
    repeat (12) cyc(0, 1, 0);
    n = 0;
    while ((m_k % STEP_DIV) != 3 && n < 2*STEP_DIV) begin
      cyc(0, 1, 0);
      n++;
    end
    repeat (8) cyc(1, 1, 0);
    repeat (25) cyc(0, 1, 0);
  endtask

  initial begin
    btn_mode = 0; run = 1; rst = 1;
    repeat (2) cyc(0, 1, 1);
    repeat (90) cyc(0, 1, 0);
    repeat (3) cyc(1, 1, 0);
    repeat (5) cyc(0, 1, 0);
    repeat (10) cyc(1, 1, 0);
    repeat (40) cyc(0, 1, 0);
    aim_press();
    aim_press();
    repeat (50) cyc(0, 1, 0);
    aim_press();
    repeat (40) cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);
    repeat (20) cyc(0, 1, 0);

    btnv = 0; runv = 1; btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        btnv = ~btnv;
        btn_left = btnv ? $urandom_range(1, 10) : $urandom_range(1, 30);
      end
      btn_left--;
      if (runv ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 14) == 0)) runv = ~runv;
      cyc(btnv, runv, $urandom_range(0, 999) == 0);
    end

    repeat (10) cyc(0, 1, 0);
    cyc(0, 1, 1);
    repeat (25) cyc(0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
